sseg_scan: RTL and testbench
============================

SSEG_SCAN -- requirements
Module: sseg_scan

Interface
REQ-001 SHALL have parameter REFRESH_BITS, default 18: refresh counter width; count[REFRESH_BITS-1:REFRESH_BITS-2] selects the digit.
REQ-002 SHALL have parameter GUARD, default 4: number of cycles at the start of each digit slot with all anodes off.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port load, input, 1: one-cycle strobe that captures value, err and dp_in.
REQ-006 SHALL have port value, input, 16: four hex digits; [3:0] is digit0 (rightmost).
REQ-007 SHALL have port err, input, 1: error display request, captured with load.
REQ-008 SHALL have port dp_in, input, 4: per-digit decimal point, 1 = lit.
REQ-009 SHALL have port digit_en, input, 4: per-digit enable, live (not captured).
REQ-010 SHALL have port sseg, output, 7: active-low segments {g,f,e,d,c,b,a}, registered.
REQ-011 SHALL have port an, output, 4: active-low anodes, registered.
REQ-012 SHALL have port dp, output, 1: active-low decimal point, registered.
REQ-013 SHALL have port busy, output, 1: a captured value is pending and not yet shown.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when a pending value is committed to the display.

Function
REQ-015 SHALL implement a free-running REFRESH_BITS-bit counter cnt, incrementing by 1 each cycle and wrapping from all-ones to 0.
REQ-016 SHALL derive sel = cnt[top:top-1]; sel 0..3 drives digit0..3 with an = 1110, 1101, 1011, 0111 respectively.
REQ-017 SHALL force an = 1111, sseg = 1111111 and dp = 1 while cnt[REFRESH_BITS-3:0] < GUARD.
REQ-018 SHALL treat a digit as blank (an bit 1, sseg 1111111, dp 1) during its slot when digit_en[sel] = 0.
REQ-019 SHALL, on load = 1, capture value, err and dp_in into pending registers and set busy on the next cycle; a later load overwrites the pending contents (last wins).
REQ-020 SHALL commit at the edge where cnt = all-ones: the display registers take the pending contents, busy clears, and done = 1 for the following cycle only.
REQ-021 SHALL, when load and cnt = all-ones occur on the same cycle, commit the new inputs directly; busy stays 0 and done pulses.
REQ-022 SHALL, at a commit with busy = 0 and no load, leave the display unchanged and not pulse done.
REQ-023 SHALL use hex encoding 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-024 SHALL, when the displayed err = 1, show digit1 = E (0000110), digit0 = r (0101111), and digits 3:2 blank with dp off, regardless of value.
REQ-025 SHALL drive dp = ~dp_disp[sel] within enabled, non-guard slots.
REQ-026 SHALL register sseg, an and dp one cycle after the cnt value they decode; display changes never occur mid-frame.

Reset
REQ-027 SHALL, while rst = 0, immediately set cnt = 0, the display and pending registers to 0, err_disp = 0, busy = 0, done = 0, an = 1111, sseg = 1111111 and dp = 1.
REQ-028 SHALL discard a pending value when reset is asserted mid-frame; after release, digit 0 shows 0 once the first guard interval ends.

Verification (REFRESH_BITS=6, GUARD=4: slot 16 cycles, frame 64)
REQ-029 SHALL be verified by: reset release, digit_en=1111 -> digit slots at cnt 4..15 / 20..31 / 36..47 / 52..63 show an 1110/1101/1011/0111 with sseg 1000000; an=1111 in guard cycles.
REQ-030 SHALL be verified by: load value=16'h00A5 at cnt=10 -> busy=1 until commit at cnt=63, done pulse, next frame digit0=0010010, digit1=0001000.
REQ-031 SHALL be verified by: loads 16'h1234 (cnt 5) then 16'h5678 (cnt 20) in the same frame -> single done pulse, display 5678, 1234 never shown.
REQ-032 SHALL be verified by: load 16'h00FF at cnt=63 -> busy stays 0, done pulses, next frame shows FF.
REQ-033 SHALL be verified by: load err=1 with value=16'h0042 -> digit1=0000110, digit0=0101111, an[3:2] stay 1.
REQ-034 SHALL be verified by: digit_en=0011, dp_in=0001 -> an[3:2] never 0; dp=0 only in the digit0 slot; reset asserted at cnt=30 with busy=1 -> all outputs return to reset values and busy=0.

Source files
------------

// File: rtl/sseg_scan.sv
// Four-digit multiplexed seven-segment driver with guard-banded digit slots.
// A loaded value waits in a pending buffer and is committed only at frame end.
module sseg_scan #(
  parameter int REFRESH_BITS = 18,
  parameter int GUARD        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        err,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [6:0]  sseg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        busy,
  output logic        done
);

  localparam int SLOT_W = REFRESH_BITS - 2;
  localparam logic [REFRESH_BITS-1:0] CNT_MAX = '1;

  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic [15:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic        pend_err_q, pend_err_d, disp_err_q, disp_err_d;
  logic [3:0]  pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [6:0]  sseg_q, sseg_d;
  logic [3:0]  an_q, an_d;
  logic        dp_q, dp_d;
  logic [1:0]  sel_s;
  logic        wrap_s, guard_s, blank_s;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      4'hF:    hex7 = 7'b0001110;
      default: hex7 = 7'b1111111;
    endcase
  endfunction

  assign wrap_s  = (cnt_q == CNT_MAX);
  assign sel_s   = cnt_q[REFRESH_BITS-1 -: 2];
  assign guard_s = (cnt_q[SLOT_W-1:0] < SLOT_W'(GUARD));
  // Error mode shows only "Er" on the two right-hand digits.
  assign blank_s = guard_s | ~digit_en[sel_s] | (disp_err_q & sel_s[1]);

  // Pending buffer, frame-end commit and refresh counter next state.
  always_comb begin
    cnt_d      = cnt_q + REFRESH_BITS'(1);
    pend_val_d = pend_val_q;
    pend_err_d = pend_err_q;
    pend_dp_d  = pend_dp_q;
    disp_val_d = disp_val_q;
    disp_err_d = disp_err_q;
    disp_dp_d  = disp_dp_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (wrap_s) begin
      if (load) begin
        disp_val_d = value;
        disp_err_d = err;
        disp_dp_d  = dp_in;
        busy_d     = 1'b0;
        done_d     = 1'b1;
      end else if (busy_q) begin
        disp_val_d = pend_val_q;
        disp_err_d = pend_err_q;
        disp_dp_d  = pend_dp_q;
        busy_d     = 1'b0;
        done_d     = 1'b1;
      end else begin
        done_d     = 1'b0;
      end
    end else if (load) begin
      pend_val_d = value;
      pend_err_d = err;
      pend_dp_d  = dp_in;
      busy_d     = 1'b1;
    end else begin
      busy_d     = busy_q;
    end
  end

  // Decode of the current slot into the next output register values.
  always_comb begin
    an_d   = 4'b1111;
    sseg_d = 7'b1111111;
    dp_d   = 1'b1;
    if (!blank_s) begin
      an_d = ~(4'b0001 << sel_s);
      if (disp_err_q) begin
        sseg_d = sel_s[0] ? 7'b0000110 : 7'b0101111;
      end else begin
        sseg_d = hex7(disp_val_q[{sel_s, 2'b00} +: 4]);
      end
      dp_d = ~disp_dp_q[sel_s];
    end else begin
      an_d = 4'b1111;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      pend_val_q <= 16'h0000;
      pend_err_q <= 1'b0;
      pend_dp_q  <= 4'b0000;
      disp_val_q <= 16'h0000;
      disp_err_q <= 1'b0;
      disp_dp_q  <= 4'b0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sseg_q     <= 7'b1111111;
      an_q       <= 4'b1111;
      dp_q       <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      pend_val_q <= pend_val_d;
      pend_err_q <= pend_err_d;
      pend_dp_q  <= pend_dp_d;
      disp_val_q <= disp_val_d;
      disp_err_q <= disp_err_d;
      disp_dp_q  <= disp_dp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sseg_q     <= sseg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
    end
  end

  assign sseg = sseg_q;
  assign an   = an_q;
  assign dp   = dp_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sseg_scan.sv
// Randomized and directed bench for sseg_scan against a frame-level model
// (REFRESH_BITS=6, GUARD=4: 16-cycle slots, 64-cycle frames).
module tb_sseg_scan;

  localparam int RB = 6;
  localparam int GD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        err = 1'b0;
  logic [3:0]  dp_in = 4'b0000;
  logic [3:0]  digit_en = 4'b1111;
  logic [6:0]  sseg;
  logic [3:0]  an;
  logic        dp, busy, done;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: the display state as the spec describes it.
  int          m_cnt;
  logic [15:0] m_pval, m_dval;
  logic        m_perr, m_derr, m_busy, m_done;
  logic [3:0]  m_pdp, m_ddp;

  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  sseg_scan #(.REFRESH_BITS(RB), .GUARD(GD)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .err(err),
    .dp_in(dp_in), .digit_en(digit_en), .sseg(sseg), .an(an), .dp(dp),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cnt=%0d)", tag, got, exp, m_cnt);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pval = 16'h0; m_dval = 16'h0; m_perr = 1'b0; m_derr = 1'b0;
    m_busy = 1'b0; m_done = 1'b0; m_pdp = 4'h0; m_ddp = 4'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_an"}, 32'(an), 32'hF);
    check_val({tag, "_sseg"}, 32'(sseg), 32'h7F);
    check_val({tag, "_dp"}, 32'(dp), 32'h1);
    check_val({tag, "_busy"}, 32'(busy), 32'h0);
    check_val({tag, "_done"}, 32'(done), 32'h0);
  endtask

  // One clock: apply inputs at negedge, predict, check just after posedge.
  task automatic step(input logic ld, input logic [15:0] v, input logic er, input logic [3:0] d);
    logic [3:0] e_an;
    logic [6:0] e_sg;
    logic       e_dp;
    int sel, off;
    load = ld; value = v; err = er; dp_in = d;
    sel = m_cnt / 16;
    off = m_cnt % 16;
    e_an = 4'hF; e_sg = 7'h7F; e_dp = 1'b1;
    if (off >= GD && digit_en[sel] && !(m_derr && sel >= 2)) begin
      e_an = an_tab[sel];
      if (m_derr) e_sg = (sel == 1) ? 7'b0000110 : 7'b0101111;
      else        e_sg = hex_tab[(m_dval >> (4 * sel)) & 16'hF];
      e_dp = ~m_ddp[sel];
    end
    if (m_cnt == 63) begin
      if (ld) begin
        m_dval = v; m_derr = er; m_ddp = d; m_busy = 1'b0; m_done = 1'b1;
      end else if (m_busy) begin
        m_dval = m_pval; m_derr = m_perr; m_ddp = m_pdp; m_busy = 1'b0; m_done = 1'b1;
      end else begin
        m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      if (ld) begin
        m_pval = v; m_perr = er; m_pdp = d; m_busy = 1'b1;
      end
    end
    m_cnt = (m_cnt + 1) % 64;
    @(posedge clk);
    #1;
    check_val("an", 32'(an), 32'(e_an));
    check_val("sseg", 32'(sseg), 32'(e_sg));
    check_val("dp", 32'(dp), 32'(e_dp));
    check_val("busy", 32'(busy), 32'(m_busy));
    check_val("done", 32'(done), 32'(m_done));
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 4'h0);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 64 && m_cnt != target; i++) step(1'b0, 16'h0, 1'b0, 4'h0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b1;

    // Power-on frame with all digits enabled, value 0.
    idle(64);

    // Single load mid-frame, commit at frame end.
    run_to(10);
    step(1'b1, 16'h00A5, 1'b0, 4'h0);
    idle(80);

    // Two loads in a frame: last wins, one commit.
    run_to(5);
    step(1'b1, 16'h1234, 1'b0, 4'h0);
    run_to(20);
    step(1'b1, 16'h5678, 1'b0, 4'h0);
    idle(100);

    // Load coinciding with the wrap commits directly.
    run_to(63);
    step(1'b1, 16'h00FF, 1'b0, 4'h0);
    idle(80);

    // Error display.
    run_to(30);
    step(1'b1, 16'h0042, 1'b1, 4'h0);
    idle(100);

    // Partial enables and a decimal point on digit 0.
    digit_en = 4'b0011;
    run_to(8);
    step(1'b1, 16'h9C3E, 1'b0, 4'b0001);
    idle(100);

    // Reset mid-frame with a pending value.
    run_to(10);
    step(1'b1, 16'hBEEF, 1'b0, 4'b1111);
    run_to(30);
    check_val("pre_rst_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    digit_en = 4'b1111;
    idle(70);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 31) == 0) digit_en = 4'($urandom);
      step($urandom_range(0, 19) == 0, 16'($urandom), $urandom_range(0, 7) == 0, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
